// File: rtl/dataflow_pkg.sv
// Pipeline stage types and the memory-arbiter request/state types.
package dataflow_pkg;
  import extensions_pkg::*;

  typedef enum logic [2:0] {StageIf, StageId, StageEx, StageMem, StageWb} pipe_stage_t;

  typedef enum logic [1:0] {Idle, FetchBusy, DataBusy} arbiter_state_t;

  typedef struct packed {
    logic [DataSize-1:0]   addr;
    logic [DataSize-1:0]   wr_data;
    logic [DataSize/8-1:0] byte_en;
    logic                  we;
  } mem_req_t;

  // Picks the 32-bit instruction out of a bus word; word_hi is address bit 2.
  function automatic logic [31:0] select_instr(input logic [DataSize-1:0] dat, input logic word_hi);
    logic [63:0] wide;
    wide = 64'(dat);
    if (DataSize == 64 && word_hi) return wide[63:32];
    return wide[31:0];
  endfunction
endpackage

// File: rtl/extensions_pkg.sv
// Core-wide build options shared by the pipeline blocks.
package extensions_pkg;
  localparam int DataSize = 64;
endpackage

// File: rtl/pipeline_mem_arbiter.sv
// Shares the external memory bus between instruction fetch and data access,
// with pipeline stall generation and a bus watchdog.
module pipeline_mem_arbiter
  import extensions_pkg::*;
  import dataflow_pkg::*;
#(
  parameter int TimeoutCycles = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [DataSize-1:0]   if_addr,
  output logic                  if_ack,
  output logic [31:0]           if_rd_data,
  input  logic                  dm_rd_en,
  input  logic                  dm_wr_en,
  input  logic [DataSize-1:0]   dm_addr,
  input  logic [DataSize-1:0]   dm_wr_data,
  input  logic [DataSize/8-1:0] dm_byte_en,
  output logic                  dm_ack,
  output logic [DataSize-1:0]   dm_rd_data,
  output logic                  bus_cyc,
  output logic                  bus_stb,
  output logic                  bus_we,
  output logic [DataSize-1:0]   bus_addr,
  output logic [DataSize-1:0]   bus_dat_o,
  output logic [DataSize/8-1:0] bus_sel,
  input  logic [DataSize-1:0]   bus_dat_i,
  input  logic                  bus_ack,
  input  logic                  flush,
  output logic                  stall_if,
  output logic                  stall_mem,
  output logic                  bus_timeout,
  output arbiter_state_t        state_dbg
);

  localparam logic [7:0] WdLimit = 8'(TimeoutCycles - 1);

  arbiter_state_t state;
  logic [7:0]     wd_cnt;
  logic           flushed;
  logic           dm_req, dm_pending, if_pending;
  logic           wd_expire, cycle_end;
  mem_req_t       fetch_req, data_req, grant_req;

  // Handshake: a requester holds its request until it sees its one-cycle ack;
  // during that ack cycle the still-high request is stale and is not arbitrated.
  assign dm_req     = dm_rd_en | dm_wr_en;
  assign dm_pending = dm_req & ~dm_ack;
  assign if_pending = if_req & ~if_ack;
  assign stall_if   = if_req & ~if_ack;
  assign stall_mem  = dm_req & ~dm_ack;
  assign wd_expire  = (wd_cnt == WdLimit) & ~bus_ack;
  assign cycle_end  = bus_ack | wd_expire;
  assign state_dbg  = state;

  always_comb begin
    fetch_req = '{addr: if_addr, wr_data: '0, byte_en: '1, we: 1'b0};
    data_req  = '{addr: dm_addr, wr_data: dm_wr_data, byte_en: dm_byte_en, we: dm_wr_en};
    grant_req = dm_pending ? data_req : fetch_req;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= Idle;
      wd_cnt      <= '0;
      flushed     <= 1'b0;
      if_ack      <= 1'b0;
      if_rd_data  <= '0;
      dm_ack      <= 1'b0;
      dm_rd_data  <= '0;
      bus_cyc     <= 1'b0;
      bus_stb     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_dat_o   <= '0;
      bus_sel     <= '0;
      bus_timeout <= 1'b0;
    end else begin
      if_ack      <= 1'b0;
      dm_ack      <= 1'b0;
      bus_timeout <= 1'b0;
      case (state)
        Idle: begin
          // Data wins: the Memory stage holds the older instruction.
          if (dm_pending || if_pending) begin
            state     <= dm_pending ? DataBusy : FetchBusy;
            bus_cyc   <= 1'b1;
            bus_stb   <= 1'b1;
            bus_we    <= grant_req.we;
            bus_addr  <= grant_req.addr;
            bus_dat_o <= grant_req.wr_data;
            bus_sel   <= grant_req.byte_en;
            wd_cnt    <= '0;
            flushed   <= 1'b0;
          end
        end
        FetchBusy, DataBusy: begin
          if (state == FetchBusy && flush) flushed <= 1'b1;
          if (cycle_end) begin
            state       <= Idle;
            bus_cyc     <= 1'b0;
            bus_stb     <= 1'b0;
            bus_timeout <= wd_expire;
            if (state == FetchBusy) begin
              // A flushed fetch still finishes on the bus but is never handed back.
              if_ack     <= ~(flushed | flush);
              if_rd_data <= wd_expire ? 32'h0 : select_instr(bus_dat_i, bus_addr[2]);
            end else begin
              dm_ack     <= 1'b1;
              dm_rd_data <= wd_expire ? '0 : bus_dat_i;
            end
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        default: state <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Self-checking bench for pipeline_mem_arbiter: bus slave model, scenario tasks, scoreboard queue.
module tb_pipeline_mem_arbiter;
  import extensions_pkg::*;
  import dataflow_pkg::*;

  logic clock, reset;
  logic if_req, flush, dm_rd_en, dm_wr_en, bus_ack;
  logic [63:0] if_addr, dm_addr, dm_wr_data, bus_dat_i;
  logic [7:0]  dm_byte_en;
  logic if_ack, dm_ack, bus_cyc, bus_stb, bus_we, stall_if, stall_mem, bus_timeout;
  logic [31:0] if_rd_data;
  logic [63:0] dm_rd_data, bus_addr, bus_dat_o;
  logic [7:0]  bus_sel;
  arbiter_state_t state_dbg;

  logic wd_if_ack, wd_dm_ack, wd_bus_cyc, wd_bus_stb, wd_bus_we, wd_stall_if, wd_stall_mem, wd_bus_timeout;
  logic [31:0] wd_if_rd_data;
  logic [63:0] wd_dm_rd_data, wd_bus_addr, wd_bus_dat_o;
  logic [7:0]  wd_bus_sel;
  arbiter_state_t wd_state_dbg;
  logic wd_bus_ack;

  int checks = 0;
  int failures = 0;
  int cyc_no = 0;
  int idle_ack_at = -1;
  int wait_states = 0;
  bit slave_on = 1'b1;
  logic [63:0] exp_q[$];
  logic [63:0] exp_v;

  pipeline_mem_arbiter dut (
    .clock(clock), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .if_rd_data(if_rd_data), .dm_rd_en(dm_rd_en), .dm_wr_en(dm_wr_en), .dm_addr(dm_addr),
    .dm_wr_data(dm_wr_data), .dm_byte_en(dm_byte_en), .dm_ack(dm_ack), .dm_rd_data(dm_rd_data),
    .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr), .bus_dat_o(bus_dat_o),
    .bus_sel(bus_sel), .bus_dat_i(bus_dat_i), .bus_ack(bus_ack), .flush(flush), .stall_if(stall_if),
    .stall_mem(stall_mem), .bus_timeout(bus_timeout), .state_dbg(state_dbg)
  );

  // Short-watchdog instance; its bus never acknowledges.
  pipeline_mem_arbiter #(.TimeoutCycles(4)) dut_wd (
    .clock(clock), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_ack(wd_if_ack),
    .if_rd_data(wd_if_rd_data), .dm_rd_en(dm_rd_en), .dm_wr_en(dm_wr_en), .dm_addr(dm_addr),
    .dm_wr_data(dm_wr_data), .dm_byte_en(dm_byte_en), .dm_ack(wd_dm_ack), .dm_rd_data(wd_dm_rd_data),
    .bus_cyc(wd_bus_cyc), .bus_stb(wd_bus_stb), .bus_we(wd_bus_we), .bus_addr(wd_bus_addr),
    .bus_dat_o(wd_bus_dat_o), .bus_sel(wd_bus_sel), .bus_dat_i(bus_dat_i), .bus_ack(wd_bus_ack),
    .flush(flush), .stall_if(wd_stall_if), .stall_mem(wd_stall_mem), .bus_timeout(wd_bus_timeout),
    .state_dbg(wd_state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc_no <= cyc_no + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish before 500us");
    $fatal(1, "bench hung");
  end

  // ---------------- memory model ----------------
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (a == 64'h100) return {32'h1111_2222, 32'h00A0_0093};
    return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
  endfunction

  function automatic logic [63:0] fetch_word(input logic [63:0] a);
    logic [63:0] w;
    w = mem_word(a);
    return {32'h0, (a[2] ? w[63:32] : w[31:0])};
  endfunction

  // Bus slave: acks after wait_states strobe cycles, returning mem_word(bus_addr).
  initial begin
    int wcnt;
    wcnt = 0;
    bus_ack = 1'b0;
    bus_dat_i = '0;
    wd_bus_ack = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      bus_ack = 1'b0;
      if (cyc_no == idle_ack_at) begin
        bus_ack = 1'b1;
      end else if (slave_on && bus_stb) begin
        if (wcnt == wait_states) begin
          bus_ack = 1'b1;
          bus_dat_i = mem_word(bus_addr);
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    if_req = 0; flush = 0; dm_rd_en = 0; dm_wr_en = 0;
    if_addr = '0; dm_addr = '0; dm_wr_data = '0; dm_byte_en = '0;
  endtask

  // which: 0 = if_ack, 1 = dm_ack, 2 = watchdog-instance dm_ack. at = -1 when the bound expires.
  task automatic wait_ack(input int which, input int start, input int limit, output int at);
    at = -1;
    for (int c = start; c <= limit; c++) begin
      if (c != start) begin
        tick();
        sample();
      end
      if ((which == 0 && if_ack) || (which == 1 && dm_ack) || (which == 2 && wd_dm_ack)) begin
        at = c;
        return;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (3) tick();
    sample();
    checks++;
    if ({bus_cyc, bus_stb, bus_we, if_ack, dm_ack, bus_timeout} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b required 000000", {bus_cyc, bus_stb, bus_we, if_ack, dm_ack, bus_timeout});
    end
    checks++;
    if ({bus_addr, bus_dat_o, bus_sel, if_rd_data, dm_rd_data} !== '0) begin
      failures++;
      $display("FAIL reset_data: addr=%h dat_o=%h sel=%h ird=%h drd=%h required all 0", bus_addr, bus_dat_o, bus_sel, if_rd_data, dm_rd_data);
    end
    checks++;
    if (state_dbg !== Idle || stall_if !== 1'b0 || stall_mem !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got state=%0d stall_if=%b stall_mem=%b required Idle 0 0", state_dbg, stall_if, stall_mem);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    int at;
    wait_states = 1;
    tick();
    if_req = 1; if_addr = 64'h100;
    exp_q.push_back(fetch_word(64'h100));
    sample();
    checks++;
    if (stall_if !== 1'b1 || bus_cyc !== 1'b0) begin
      failures++;
      $display("FAIL fetch_c0: got stall_if=%b cyc=%b required 1 0", stall_if, bus_cyc);
    end
    tick(); sample();
    checks++;
    if ({bus_cyc, bus_stb, bus_we, bus_sel, bus_addr, stall_if} !== {1'b1, 1'b1, 1'b0, 8'hFF, 64'h100, 1'b1}) begin
      failures++;
      $display("FAIL fetch_bus: got cyc=%b stb=%b we=%b sel=%h addr=%h stall_if=%b required 1 1 0 ff 100 1", bus_cyc, bus_stb, bus_we, bus_sel, bus_addr, stall_if);
    end
    wait_ack(0, 1, 20, at);
    checks++;
    if (at !== 3) begin failures++; $display("FAIL fetch_latency: got cycle %0d required 3", at); end
    exp_v = exp_q.pop_front();
    checks++;
    if ({32'h0, if_rd_data} !== exp_v) begin failures++; $display("FAIL fetch_data: got %h required %h", if_rd_data, exp_v[31:0]); end
    checks++;
    if (stall_if !== 1'b0) begin failures++; $display("FAIL fetch_stall_release: got %b required 0", stall_if); end
    tick();
    if_req = 0;
    sample();
    checks++;
    if (if_ack !== 1'b0 || bus_cyc !== 1'b0) begin
      failures++;
      $display("FAIL fetch_pulse: got if_ack=%b cyc=%b required 0 0", if_ack, bus_cyc);
    end
  endtask

  task automatic test_priority();
    int at;
    wait_states = 0;
    tick();
    if_req = 1; if_addr = 64'h100; dm_rd_en = 1; dm_addr = 64'h2000;
    exp_q.push_back(mem_word(64'h2000));
    exp_q.push_back(fetch_word(64'h100));
    tick(); sample();
    checks++;
    if (bus_addr !== 64'h2000 || bus_we !== 1'b0 || state_dbg !== DataBusy) begin
      failures++;
      $display("FAIL prio_grant: got addr=%h we=%b state=%0d required 2000 0 DataBusy", bus_addr, bus_we, state_dbg);
    end
    wait_ack(1, 1, 20, at);
    checks++;
    if (at !== 2) begin failures++; $display("FAIL prio_dm_latency: got cycle %0d required 2", at); end
    exp_v = exp_q.pop_front();
    checks++;
    if (dm_rd_data !== exp_v || if_ack !== 1'b0 || bus_cyc !== 1'b0) begin
      failures++;
      $display("FAIL prio_dm_data: got data=%h if_ack=%b cyc=%b required %h 0 0", dm_rd_data, if_ack, bus_cyc, exp_v);
    end
    tick();
    dm_rd_en = 0;
    sample();
    checks++;
    if (bus_cyc !== 1'b1 || bus_addr !== 64'h100 || state_dbg !== FetchBusy) begin
      failures++;
      $display("FAIL prio_fetch_grant: got cyc=%b addr=%h state=%0d required 1 100 FetchBusy", bus_cyc, bus_addr, state_dbg);
    end
    wait_ack(0, 3, 20, at);
    checks++;
    if (at !== 4) begin failures++; $display("FAIL prio_if_latency: got cycle %0d required 4", at); end
    exp_v = exp_q.pop_front();
    checks++;
    if ({32'h0, if_rd_data} !== exp_v) begin failures++; $display("FAIL prio_if_data: got %h required %h", if_rd_data, exp_v[31:0]); end
    tick();
    if_req = 0;
  endtask

  task automatic test_store();
    int at;
    wait_states = 4;
    tick();
    dm_wr_en = 1; dm_addr = 64'h3000; dm_wr_data = 64'hDEADBEEF; dm_byte_en = 8'h03;
    tick(); sample();
    checks++;
    if ({bus_cyc, bus_we, bus_sel, bus_dat_o, bus_addr, stall_mem} !== {1'b1, 1'b1, 8'h03, 64'hDEADBEEF, 64'h3000, 1'b1}) begin
      failures++;
      $display("FAIL store_bus: got cyc=%b we=%b sel=%h dat=%h addr=%h stall_mem=%b", bus_cyc, bus_we, bus_sel, bus_dat_o, bus_addr, stall_mem);
    end
    tick(); tick(); sample();
    checks++;
    if ({bus_stb, bus_we, bus_sel, bus_dat_o, bus_addr} !== {1'b1, 1'b1, 8'h03, 64'hDEADBEEF, 64'h3000}) begin
      failures++;
      $display("FAIL store_stable: got stb=%b we=%b sel=%h dat=%h addr=%h", bus_stb, bus_we, bus_sel, bus_dat_o, bus_addr);
    end
    wait_ack(1, 3, 20, at);
    checks++;
    if (at !== 6) begin failures++; $display("FAIL store_latency: got cycle %0d required 6", at); end
    checks++;
    if (stall_mem !== 1'b0 || bus_cyc !== 1'b0) begin
      failures++;
      $display("FAIL store_done: got stall_mem=%b cyc=%b required 0 0", stall_mem, bus_cyc);
    end
    tick();
    dm_wr_en = 0;
  endtask

  task automatic test_flush();
    int at;
    bit seen_ack;
    wait_states = 3;
    tick();
    if_req = 1; if_addr = 64'h100;
    tick();
    tick();
    flush = 1;
    tick();
    flush = 0;
    seen_ack = 0;
    for (int c = 3; c <= 5; c++) begin
      if (c != 3) tick();
      if (c == 5) begin
        if_addr = 64'h104;
        exp_q.push_back(fetch_word(64'h104));
      end
      sample();
      if (if_ack) seen_ack = 1;
    end
    checks++;
    if (seen_ack !== 1'b0 || bus_cyc !== 1'b0) begin
      failures++;
      $display("FAIL flush_suppress: got if_ack_seen=%b cyc=%b required 0 0", seen_ack, bus_cyc);
    end
    tick(); sample();
    checks++;
    if (bus_cyc !== 1'b1 || bus_addr !== 64'h104) begin
      failures++;
      $display("FAIL flush_regrant: got cyc=%b addr=%h required 1 104", bus_cyc, bus_addr);
    end
    wait_ack(0, 6, 30, at);
    checks++;
    if (at !== 10) begin failures++; $display("FAIL flush_regrant_latency: got cycle %0d required 10", at); end
    exp_v = exp_q.pop_front();
    checks++;
    if ({32'h0, if_rd_data} !== exp_v) begin failures++; $display("FAIL flush_upper_word: got %h required %h", if_rd_data, exp_v[31:0]); end
    tick();
    if_req = 0;
    tick();
    // Flush arriving in the same cycle as bus_ack.
    wait_states = 1;
    tick();
    if_req = 1; if_addr = 64'h100;
    tick();
    tick();
    flush = 1;
    tick();
    flush = 0; if_req = 0;
    sample();
    checks++;
    if (if_ack !== 1'b0 || bus_cyc !== 1'b0) begin
      failures++;
      $display("FAIL flush_same_cycle: got if_ack=%b cyc=%b required 0 0", if_ack, bus_cyc);
    end
    tick();
  endtask

  task automatic test_timeout();
    int at;
    reset = 0;
    tick();
    reset = 1;
    slave_on = 0;
    tick();
    tick();
    dm_rd_en = 1; dm_addr = 64'h4000;
    tick(); sample();
    checks++;
    if (wd_bus_cyc !== 1'b1) begin failures++; $display("FAIL wd_start: got cyc=%b required 1", wd_bus_cyc); end
    tick(); tick(); tick(); sample();
    checks++;
    if (wd_bus_cyc !== 1'b1 || wd_bus_timeout !== 1'b0) begin
      failures++;
      $display("FAIL wd_cycle4: got cyc=%b timeout=%b required 1 0", wd_bus_cyc, wd_bus_timeout);
    end
    wait_ack(2, 4, 20, at);
    checks++;
    if (at !== 5) begin failures++; $display("FAIL wd_latency: got cycle %0d required 5", at); end
    checks++;
    if (wd_bus_cyc !== 1'b0 || wd_bus_timeout !== 1'b1 || wd_dm_rd_data !== 64'h0) begin
      failures++;
      $display("FAIL wd_abort: got cyc=%b timeout=%b data=%h required 0 1 0", wd_bus_cyc, wd_bus_timeout, wd_dm_rd_data);
    end
    tick();
    dm_rd_en = 0;
    sample();
    checks++;
    if (wd_bus_timeout !== 1'b0 || wd_dm_ack !== 1'b0) begin
      failures++;
      $display("FAIL wd_pulse: got timeout=%b ack=%b required 0 0", wd_bus_timeout, wd_dm_ack);
    end
    slave_on = 1;
  endtask

  task automatic test_reset_mid();
    int at;
    reset = 0;
    tick();
    reset = 1;
    wait_states = 1;
    tick();
    tick();
    dm_rd_en = 1; dm_addr = 64'h5000;
    exp_q.push_back(mem_word(64'h5000));
    tick(); sample();
    checks++;
    if (bus_cyc !== 1'b1 || state_dbg !== DataBusy) begin
      failures++;
      $display("FAIL rstmid_busy: got cyc=%b state=%0d required 1 DataBusy", bus_cyc, state_dbg);
    end
    tick();
    reset = 0;
    tick();
    reset = 1;
    sample();
    checks++;
    if ({bus_cyc, bus_stb, bus_we, dm_ack, if_ack, bus_timeout, bus_addr, dm_rd_data} !== '0 || state_dbg !== Idle) begin
      failures++;
      $display("FAIL rstmid_clear: got cyc=%b dm_ack=%b addr=%h data=%h state=%0d required all 0 Idle", bus_cyc, dm_ack, bus_addr, dm_rd_data, state_dbg);
    end
    wait_ack(1, 3, 30, at);
    checks++;
    if (at !== 6) begin failures++; $display("FAIL rstmid_restart: got cycle %0d required 6", at); end
    exp_v = exp_q.pop_front();
    checks++;
    if (dm_rd_data !== exp_v) begin failures++; $display("FAIL rstmid_data: got %h required %h", dm_rd_data, exp_v); end
    tick();
    dm_rd_en = 0;
  endtask

  task automatic test_back_to_back();
    int at;
    logic [63:0] a;
    tick();
    idle_ack_at = cyc_no + 1;
    tick();
    tick(); sample();
    checks++;
    if (dm_ack !== 1'b0 || if_ack !== 1'b0 || bus_cyc !== 1'b0 || state_dbg !== Idle) begin
      failures++;
      $display("FAIL idle_ack_ignored: got dm_ack=%b if_ack=%b cyc=%b state=%0d required 0 0 0 Idle", dm_ack, if_ack, bus_cyc, state_dbg);
    end
    wait_states = 0;
    tick();
    dm_rd_en = 1; dm_wr_en = 1; dm_addr = 64'h7000; dm_wr_data = 64'h0123_4567_89AB_CDEF; dm_byte_en = 8'hFF;
    tick(); sample();
    checks++;
    if (bus_we !== 1'b1 || bus_dat_o !== 64'h0123_4567_89AB_CDEF) begin
      failures++;
      $display("FAIL rdwr_is_write: got we=%b dat=%h required 1 0123456789abcdef", bus_we, bus_dat_o);
    end
    wait_ack(1, 1, 20, at);
    tick();
    dm_rd_en = 0; dm_wr_en = 0;
    tick();
    // Two reads with the request held; a fresh address follows each ack.
    for (int k = 0; k < 2; k++) begin
      a = 64'h6000 + 64'(8 * k) + 64'($urandom_range(0, 7) * 16);
      if (k == 0) begin
        tick();
        dm_rd_en = 1;
      end else begin
        tick();
        sample();
        checks++;
        if (bus_cyc !== 1'b0) begin failures++; $display("FAIL b2b_gap: got cyc=%b required 0", bus_cyc); end
      end
      dm_addr = a;
      exp_q.push_back(mem_word(a));
      wait_ack(1, 0, 20, at);
      checks++;
      if (at !== ((k == 0) ? 2 : 2)) begin
        failures++;
        $display("FAIL b2b_latency%0d: got cycle %0d required 2", k, at);
      end
      exp_v = exp_q.pop_front();
      checks++;
      if (dm_rd_data !== exp_v) begin failures++; $display("FAIL b2b_data%0d: got %h required %h", k, dm_rd_data, exp_v); end
    end
    tick();
    dm_rd_en = 0;
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_inputs();
    reset = 1'b0;
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_flush();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
